linebuf_sched: RTL and testbench
================================

LINEBUF_SCHED -- requirements
Module: linebuf_sched

Interface
REQ-001 The block SHALL have parameter COLUMN_SIZE, default 1280, meaning pixels per row.
REQ-002 The block SHALL have parameter ROW_SIZE, default 1024, meaning rows per frame.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port aclr, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port data_valid, input, 1, pixel strobe from CCD capture; one pixel accepted per clk while high.
REQ-006 The block SHALL have port ram_wren, output, 3, one-hot write enable for line RAMs 0..2.
REQ-007 The block SHALL have port addr, output, 11, shared column address for all three line RAMs.
REQ-008 The block SHALL have port rd_top_sel, output, 2, index of the RAM holding row y-2.
REQ-009 The block SHALL have port rd_mid_sel, output, 2, index of the RAM holding row y-1.
REQ-010 The block SHALL have port win_valid, output, 1, 3x3 window at current addr is complete.
REQ-011 The block SHALL have port row_end, output, 1, one-cycle pulse with the last pixel of a row.
REQ-012 The block SHALL have port frame_end, output, 1, one-cycle pulse with the last pixel of a frame.

Function
REQ-013 The block SHALL implement states IDLE, FILL, RUN.
REQ-014 IDLE->FILL SHALL occur on data_valid=1; that pixel SHALL be accepted as row 0, column 0.
REQ-015 FILL->RUN SHALL occur when the last pixel of row 1 is accepted.
REQ-016 RUN->IDLE SHALL occur when the last pixel of row ROW_SIZE-1 is accepted; col, row and wr_ptr SHALL clear to 0.
REQ-017 Internal col counter SHALL increment per accepted pixel and wrap from COLUMN_SIZE-1 to 0; row counter SHALL increment on that wrap and wrap from ROW_SIZE-1 to 0.
REQ-018 Counters SHALL hold when data_valid=0; gaps mid-row SHALL NOT alter state or counts.
REQ-019 wr_ptr SHALL start at 0 and rotate 0->1->2->0 on each row wrap.
REQ-020 All outputs SHALL be registered with 1-clk latency from the accepting edge: ram_wren[wr_ptr]=1, addr=col, row_end/frame_end per accepted pixel.
REQ-021 ram_wren SHALL be 3'b000 in any cycle following a clk with data_valid=0.
REQ-022 rd_top_sel SHALL equal (wr_ptr+1) mod 3 and rd_mid_sel (wr_ptr+2) mod 3, registered with addr.
REQ-023 win_valid SHALL be 1 only for accepted pixels with row>=2 (state RUN), subject to REQ-030.
REQ-024 row_end and frame_end SHALL assert together on the last pixel of the last row.
REQ-025 data_valid while in IDLE after frame end SHALL start a new frame at row 0 with wr_ptr=0.

Reset
REQ-026 aclr=0 SHALL immediately force state IDLE, col=0, row=0, wr_ptr=0.
REQ-027 During reset: ram_wren=0, addr=0, rd_top_sel=1, rd_mid_sel=2, win_valid=0, row_end=0, frame_end=0.
REQ-028 Reset mid-frame SHALL abandon the frame; the first data_valid after release SHALL be row 0, column 0.

Configuration
REQ-029 Macro LINEBUF_BORDER_BLANK_EN SHALL select horizontal border suppression.
REQ-030 With LINEBUF_BORDER_BLANK_EN defined, win_valid SHALL be 0 for columns 0 and 1; without it, win_valid SHALL follow REQ-023 for all columns.

Verification (COLUMN_SIZE=4, ROW_SIZE=4)
REQ-031 Reset, then data_valid held high 16 clks -> ram_wren sequence 001 x4, 010 x4, 100 x4, 001 x4; addr 0,1,2,3 repeating.
REQ-032 Same stimulus -> row_end pulses on pixels 3,7,11,15; frame_end only on pixel 15; state returns IDLE.
REQ-033 Same stimulus, macro undefined -> win_valid=1 for pixels 8..15 only; rows 2,3 show rd_top_sel/rd_mid_sel = 0/1 then 1/2.
REQ-034 Same stimulus with LINEBUF_BORDER_BLANK_EN -> win_valid=1 only for pixels 10,11,14,15.
REQ-035 data_valid pattern 1,0,0,1 at row start -> addr 0 then 1, ram_wren 000 during the two gap cycles.
REQ-036 aclr pulsed low at pixel 6, then 4 valid pixels -> ram_wren=001, addr 0..3, win_valid=0, no frame_end.

Source files
------------

// File: rtl/linebuf_sched.sv
// linebuf_sched -- write/read scheduler for a three-line RAM buffer feeding a
// 3x3 window. It counts accepted pixels into column/row positions, picks the
// line RAM to write, and reports which RAMs hold rows y-2 and y-1.
//
// Parameters:
//   COLUMN_SIZE  pixels per row (max 2048, addr is 11 bits)
//   ROW_SIZE     rows per frame
// Ports:
//   clk          single clock, rising edge
//   aclr         asynchronous active-low reset
//   data_valid   pixel strobe, one pixel accepted per clk while high
//   ram_wren     one-hot write enable for line RAMs 0..2
//   addr         shared column address for all line RAMs
//   rd_top_sel   RAM index holding row y-2
//   rd_mid_sel   RAM index holding row y-1
//   win_valid    3x3 window at addr is complete
//   row_end      pulse with the last pixel of a row
//   frame_end    pulse with the last pixel of a frame
// All outputs are registered one clock after the accepting edge.
//
// Build option: define LINEBUF_BORDER_BLANK_EN to suppress win_valid on
// columns 0 and 1 (incomplete left border of the window).

module linebuf_sched #(
  parameter int unsigned COLUMN_SIZE = 1280,
  parameter int unsigned ROW_SIZE    = 1024
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic        data_valid,
  output logic [2:0]  ram_wren,
  output logic [10:0] addr,
  output logic [1:0]  rd_top_sel,
  output logic [1:0]  rd_mid_sel,
  output logic        win_valid,
  output logic        row_end,
  output logic        frame_end
);

  localparam int unsigned ROW_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam logic [10:0]      COL_LAST = 11'(COLUMN_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_e;

  state_e           state_q, state_d;
  logic [10:0]      col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [1:0]       wr_ptr_q, wr_ptr_d;

  logic [2:0]       ram_wren_q, ram_wren_d;
  logic [10:0]      addr_q, addr_d;
  logic [1:0]       top_q, top_d;
  logic [1:0]       mid_q, mid_d;
  logic             win_q, win_d;
  logic             row_end_q, row_end_d;
  logic             frame_end_q, frame_end_d;

  logic             last_col, last_row, border_ok;

  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);

`ifdef LINEBUF_BORDER_BLANK_EN
  assign border_ok = (col_q >= 11'd2);
`else
  assign border_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    wr_ptr_d    = wr_ptr_q;
    ram_wren_d  = '0;
    addr_d      = addr_q;
    top_d       = top_q;
    mid_d       = mid_q;
    win_d       = 1'b0;
    row_end_d   = 1'b0;
    frame_end_d = 1'b0;

    if (data_valid) begin
      ram_wren_d  = 3'b001 << wr_ptr_q;
      addr_d      = col_q;
      // Read selects are the two RAMs not being written, oldest first.
      unique case (wr_ptr_q)
        2'd0:    begin top_d = 2'd1; mid_d = 2'd2; end
        2'd1:    begin top_d = 2'd2; mid_d = 2'd0; end
        default: begin top_d = 2'd0; mid_d = 2'd1; end
      endcase
      win_d       = (state_q == RUN) && border_ok;
      row_end_d   = last_col;
      frame_end_d = last_col && last_row;

      col_d = last_col ? '0 : col_q + 11'd1;
      if (last_col) begin
        row_d    = last_row ? '0 : row_q + ROW_ONE;
        wr_ptr_d = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
      end

      unique case (state_q)
        IDLE: state_d = FILL;
        FILL: if (last_col && row_q == ROW_ONE) state_d = RUN;
        RUN: begin
          // Frame done: restart the RAM rotation at 0 rather than continuing.
          if (last_col && last_row) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      wr_ptr_q    <= '0;
      ram_wren_q  <= '0;
      addr_q      <= '0;
      top_q       <= 2'd1;
      mid_q       <= 2'd2;
      win_q       <= 1'b0;
      row_end_q   <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      wr_ptr_q    <= wr_ptr_d;
      ram_wren_q  <= ram_wren_d;
      addr_q      <= addr_d;
      top_q       <= top_d;
      mid_q       <= mid_d;
      win_q       <= win_d;
      row_end_q   <= row_end_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign ram_wren   = ram_wren_q;
  assign addr       = addr_q;
  assign rd_top_sel = top_q;
  assign rd_mid_sel = mid_q;
  assign win_valid  = win_q;
  assign row_end    = row_end_q;
  assign frame_end  = frame_end_q;

endmodule

// File: tb/tb_linebuf_sched.sv
// Scoreboard bench for linebuf_sched with a 4x4 frame. The stimulus side
// pushes the expected registered response for every accepted pixel; the
// monitor pops and compares whenever ram_wren shows a write.

module tb_linebuf_sched;

  localparam int unsigned W = 4;
  localparam int unsigned H = 4;

  logic        clk = 1'b0;
  logic        aclr = 1'b0;
  logic        data_valid = 1'b0;
  logic [2:0]  ram_wren;
  logic [10:0] addr;
  logic [1:0]  rd_top_sel, rd_mid_sel;
  logic        win_valid, row_end, frame_end;

  linebuf_sched #(.COLUMN_SIZE(W), .ROW_SIZE(H)) dut (
    .clk        (clk),
    .aclr       (aclr),
    .data_valid (data_valid),
    .ram_wren   (ram_wren),
    .addr       (addr),
    .rd_top_sel (rd_top_sel),
    .rd_mid_sel (rd_mid_sel),
    .win_valid  (win_valid),
    .row_end    (row_end),
    .frame_end  (frame_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  wren;
    logic [10:0] addr;
    logic [1:0]  top;
    logic [1:0]  mid;
    logic        win;
    logic        re;
    logic        fe;
  } exp_t;

  exp_t exp_q[$];
  int unsigned pix;        // pixel index within the current frame
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: position follows from the pixel index; the RAM holding a row
  // is row mod 3 because every frame starts writing at RAM 0.
  task automatic push_expected();
    exp_t e;
    int unsigned row, col;
    row = pix / W;
    col = pix % W;
    e.wren = 3'(1 << (row % 3));
    e.addr = 11'(col);
    e.top  = 2'((row + 1) % 3);
    e.mid  = 2'((row + 2) % 3);
`ifdef LINEBUF_BORDER_BLANK_EN
    e.win  = (row >= 2) && (col >= 2);
`else
    e.win  = (row >= 2);
`endif
    e.re   = (col == W - 1);
    e.fe   = (pix == W * H - 1);
    exp_q.push_back(e);
    pix = (pix + 1) % (W * H);
  endtask

  task automatic step(input logic dv);
    @(posedge clk);
    #1;
    data_valid = dv;
    if (dv) push_expected();
  endtask

  task automatic do_reset();
    step(1'b0);
    step(1'b0);
    step(1'b0);
    chk("drain_before_reset", exp_q.size(), 0);
    aclr = 1'b0;
    #2;
    chk("rst_wren", ram_wren, 3'b000);
    chk("rst_addr", addr, 11'd0);
    chk("rst_top", rd_top_sel, 2'd1);
    chk("rst_mid", rd_mid_sel, 2'd2);
    chk("rst_win", win_valid, 1'b0);
    chk("rst_row_end", row_end, 1'b0);
    chk("rst_frame_end", frame_end, 1'b0);
    exp_q.delete();
    pix = 0;
    @(posedge clk);
    #1;
    aclr = 1'b1;
  endtask

  always @(negedge clk) begin
    if (aclr) begin
      if (ram_wren != 3'b000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", ram_wren, 3'b000);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wren", ram_wren, e.wren);
          chk("addr", addr, e.addr);
          chk("rd_top_sel", rd_top_sel, e.top);
          chk("rd_mid_sel", rd_mid_sel, e.mid);
          chk("win_valid", win_valid, e.win);
          chk("row_end", row_end, e.re);
          chk("frame_end", frame_end, e.fe);
        end
      end else begin
        chk("gap_win", win_valid, 1'b0);
        chk("gap_row_end", row_end, 1'b0);
        chk("gap_frame_end", frame_end, 1'b0);
      end
    end
  end

  initial begin
    pix = 0;
    aclr = 1'b0;
    data_valid = 1'b0;
    #3;
    do_reset();

    // One full frame with data_valid held high.
    for (int i = 0; i < 16; i++) step(1'b1);
    step(1'b0);
    step(1'b0);

    // New frame starting with gaps at row start.
    step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    for (int i = 0; i < 14; i++) step(1'b1);
    step(1'b0);

    // Reset mid-frame after 6 pixels, then 4 pixels of a fresh frame.
    for (int i = 0; i < 6; i++) step(1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1);
    step(1'b0);

    // Random gaps across several frames, with one reset in the middle.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(99) < 70) ? 1'b1 : 1'b0);
      if (i == 150) do_reset();
    end

    step(1'b0);
    step(1'b0);
    step(1'b0);
    chk("final_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
